// File: rtl/variable_delayer.sv
// Programmable-depth sample delay line: circular buffer plus registered output,
// with a FILL/RUN controller that blanks the output until the new delay is primed.
module variable_delayer #(
    parameter  int WIDTH         = 8,
    parameter  int CHANNELS      = 1,
    parameter  int MAX_CYCLES    = 16,
    parameter  int DEFAULT_DELAY = 1,
    localparam int DW            = $clog2(MAX_CYCLES + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic                      in_valid,
    input  logic [DW-1:0]             delay_i,
    input  logic                      delay_load,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic                      out_valid,
    output logic [DW-1:0]             delay_q,
    output logic                      filling,
    output logic                      clamped
);

    localparam int DATA_W  = CHANNELS * WIDTH;
    localparam int ENTRY_W = DATA_W + 1;
    localparam int PW      = $clog2(MAX_CYCLES);
    localparam int SW      = DW + 1;

    typedef enum logic {S_FILL, S_RUN} state_t;

    state_t               r_state, w_state_next;
    logic [DW-1:0]        r_cnt, w_cnt_next;
    logic [DW-1:0]        r_delay_q, w_delay_next, w_new_d;
    logic                 r_init, r_clamped, w_clamp, w_load, w_emit;
    logic [PW-1:0]        r_wr_ptr, w_rd_idx;
    logic [SW-1:0]        w_rd_sum;
    logic [ENTRY_W-1:0]   r_mem [MAX_CYCLES];
    logic [ENTRY_W-1:0]   w_rd_entry, w_src_entry, w_out_next, r_out;

    // Clamp the requested delay into 1..MAX_CYCLES.
    always_comb begin
        w_clamp = 1'b0;
        w_new_d = DW'(DEFAULT_DELAY);
        if (delay_load) begin
            if (delay_i == '0) begin
                w_new_d = DW'(1);
                w_clamp = 1'b1;
            end else if (delay_i > DW'(MAX_CYCLES)) begin
                w_new_d = DW'(MAX_CYCLES);
                w_clamp = 1'b1;
            end else begin
                w_new_d = delay_i;
            end
        end
    end

    // The first edge after reset behaves like a load of DEFAULT_DELAY.
    assign w_load = delay_load | r_init;

    // Entry written D-1 edges ago: wr_ptr - (D-1) mod MAX_CYCLES, kept in range.
    assign w_rd_sum   = SW'(r_wr_ptr) + SW'(MAX_CYCLES + 1) - SW'(r_delay_q);
    assign w_rd_idx   = (w_rd_sum >= SW'(MAX_CYCLES)) ? PW'(w_rd_sum - SW'(MAX_CYCLES))
                                                      : PW'(w_rd_sum);
    assign w_rd_entry = r_mem[w_rd_idx];

    // NOTE: storage has no reset; FILL blanking guarantees stale entries never reach out.
    always_ff @(posedge clk) begin
        r_mem[r_wr_ptr] <= {in_valid, in};
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FILL;
            r_cnt     <= '0;
            r_delay_q <= DW'(DEFAULT_DELAY);
            r_init    <= 1'b1;
            r_wr_ptr  <= '0;
            r_out     <= '0;
            r_clamped <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_delay_q <= w_delay_next;
            r_init    <= 1'b0;
            r_wr_ptr  <= (r_wr_ptr == PW'(MAX_CYCLES - 1)) ? '0 : r_wr_ptr + PW'(1);
            r_out     <= w_out_next;
            r_clamped <= w_clamp;
        end
    end

    // Next state: a load arms the counter with D-2 blank edges after the load edge.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_delay_next = r_delay_q;
        if (w_load) begin
            w_delay_next = w_new_d;
            if (w_new_d == DW'(1)) begin
                w_state_next = S_RUN;
                w_cnt_next   = '0;
            end else begin
                w_state_next = S_FILL;
                w_cnt_next   = w_new_d - DW'(2);
            end
        end else if (r_state == S_FILL) begin
            if (r_cnt == '0) begin
                w_state_next = S_RUN;
            end else begin
                w_cnt_next = r_cnt - DW'(1);
            end
        end
    end

    // Output path: D=1 bypasses the buffer; blanked edges load zeros.
    always_comb begin
        w_src_entry = w_rd_entry;
        w_out_next  = '0;
        if (w_load) begin
            w_emit      = (w_new_d == DW'(1));
            w_src_entry = {in_valid, in};
        end else begin
            w_emit = (r_state == S_RUN) || (r_cnt == '0);
            if (r_delay_q == DW'(1)) begin
                w_src_entry = {in_valid, in};
            end
        end
        if (w_emit) begin
            w_out_next = w_src_entry;
        end
    end

    assign out       = r_out[DATA_W-1:0];
    assign out_valid = r_out[DATA_W];
    assign delay_q   = r_delay_q;
    assign filling   = (r_state == S_FILL);
    assign clamped   = r_clamped;

endmodule

// File: tb/tb_variable_delayer.sv
// Directed self-checking bench for variable_delayer (WIDTH=8, CHANNELS=2, MAX_CYCLES=16).
module tb_variable_delayer;

    localparam int WIDTH         = 8;
    localparam int CHANNELS      = 2;
    localparam int MAX_CYCLES    = 16;
    localparam int DEFAULT_DELAY = 1;
    localparam int DW            = 5;
    localparam int DATA_W        = WIDTH * CHANNELS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] in = '0;
    logic              in_valid = 1'b0;
    logic [DW-1:0]     delay_i = '0;
    logic              delay_load = 1'b0;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic [DW-1:0]     delay_q;
    logic              filling;
    logic              clamped;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    // Stimulus record: {in_valid, in} as sampled at each edge number.
    logic [DATA_W:0] hist [0:4095];

    variable_delayer #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS),
        .MAX_CYCLES(MAX_CYCLES), .DEFAULT_DELAY(DEFAULT_DELAY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid),
        .delay_i(delay_i), .delay_load(delay_load), .out(out),
        .out_valid(out_valid), .delay_q(delay_q), .filling(filling), .clamped(clamped)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pat(input int t);
        return {8'(t * 7 + 3), 8'(t)};
    endfunction

    task automatic set_in(input logic [DATA_W-1:0] d, input logic v);
        in       = d;
        in_valid = v;
        hist[cyc + 1] = {v, d};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc        = cyc + 1;
        delay_load = 1'b0;
        set_in(pat(cyc + 1), 1'b1);
    endtask

    task automatic load(input logic [DW-1:0] d);
        delay_i    = d;
        delay_load = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(16'hFFFF, 1'b1);
        repeat (2) tick();
        checks++; if (out !== '0) begin errors++; $display("FAIL reset_out: got %h want 0", out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (clamped !== 1'b0) begin errors++; $display("FAIL reset_clamped: got %b want 0", clamped); end
        checks++; if (delay_q !== DW'(DEFAULT_DELAY)) begin errors++; $display("FAIL reset_delay_q: got %0d want %0d", delay_q, DEFAULT_DELAY); end
    endtask

    task automatic test_default_delay();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({out_valid, out} !== hist[cyc]) begin
                errors++; $display("FAIL d1_stream edge %0d: got %h want %h", cyc, {out_valid, out}, hist[cyc]);
            end
            checks++; if (filling !== 1'b0) begin errors++; $display("FAIL d1_filling: got %b want 0", filling); end
        end
    endtask

    task automatic test_load_five();
        load(5'd5);
        set_in(16'h0A0A, 1'b1);
        tick();
        checks++; if (delay_q !== 5'd5) begin errors++; $display("FAIL d5_delay_q: got %0d want 5", delay_q); end
        checks++; if (clamped !== 1'b0) begin errors++; $display("FAIL d5_clamped: got %b want 0", clamped); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++;
            if ({out_valid, out} !== 17'h0) begin errors++; $display("FAIL d5_blank %0d: got %h want 0", i, {out_valid, out}); end
            checks++; if (filling !== 1'b1) begin errors++; $display("FAIL d5_filling %0d: got %b want 1", i, filling); end
        end
        tick();
        checks++; if ({out_valid, out} !== 17'h10A0A) begin errors++; $display("FAIL d5_first: got %h want 10a0a", {out_valid, out}); end
        checks++; if (filling !== 1'b0) begin errors++; $display("FAIL d5_run: got %b want 0", filling); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({out_valid, out} !== hist[cyc - 4]) begin errors++; $display("FAIL d5_stream: got %h want %h", {out_valid, out}, hist[cyc - 4]); end
        end
    endtask

    task automatic test_clamp();
        int k;
        load(5'd0);
        tick();
        checks++; if (delay_q !== 5'd1) begin errors++; $display("FAIL clamp_lo_delay_q: got %0d want 1", delay_q); end
        checks++; if (clamped !== 1'b1) begin errors++; $display("FAIL clamp_lo_pulse: got %b want 1", clamped); end
        checks++; if ({out_valid, out} !== hist[cyc]) begin errors++; $display("FAIL clamp_lo_noblank: got %h want %h", {out_valid, out}, hist[cyc]); end
        tick();
        checks++; if (clamped !== 1'b0) begin errors++; $display("FAIL clamp_lo_end: got %b want 0", clamped); end
        load(5'd31);
        tick();
        k = cyc;
        checks++; if (delay_q !== 5'd16) begin errors++; $display("FAIL clamp_hi_delay_q: got %0d want 16", delay_q); end
        checks++; if (clamped !== 1'b1) begin errors++; $display("FAIL clamp_hi_pulse: got %b want 1", clamped); end
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) begin
                checks++; if (clamped !== 1'b0) begin errors++; $display("FAIL clamp_hi_end: got %b want 0", clamped); end
            end
            checks++;
            if (cyc - k <= 14) begin
                if ({out_valid, out} !== 17'h0) begin errors++; $display("FAIL d16_blank edge %0d: got %h want 0", cyc - k, {out_valid, out}); end
            end else if ({out_valid, out} !== hist[cyc - 15]) begin
                errors++; $display("FAIL d16_stream edge %0d: got %h want %h", cyc - k, {out_valid, out}, hist[cyc - 15]);
            end
        end
    endtask

    task automatic test_reload_in_fill();
        int k2;
        load(5'd8);
        tick();
        checks++; if ({out_valid, out} !== 17'h0) begin errors++; $display("FAIL reload_blank_a: got %h want 0", {out_valid, out}); end
        tick();
        checks++; if ({out_valid, out} !== 17'h0) begin errors++; $display("FAIL reload_blank_b: got %h want 0", {out_valid, out}); end
        load(5'd3);
        tick();
        k2 = cyc;
        checks++; if (delay_q !== 5'd3) begin errors++; $display("FAIL reload_delay_q: got %0d want 3", delay_q); end
        for (int i = 0; i < 2; i++) begin
            if (i > 0) tick();
            checks++;
            if ({out_valid, out} !== 17'h0 || filling !== 1'b1) begin
                errors++; $display("FAIL reload_blank_%0d: got %h filling %b want 0 filling 1", i, {out_valid, out}, filling);
            end
        end
        tick();
        checks++; if ({out_valid, out} !== hist[k2]) begin errors++; $display("FAIL reload_first: got %h want %h", {out_valid, out}, hist[k2]); end
        checks++; if (filling !== 1'b0) begin errors++; $display("FAIL reload_run: got %b want 0", filling); end
    endtask

    task automatic test_valid_pattern();
        logic [3:0] vp;
        vp = 4'b1101;
        load(5'd4);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(pat(cyc + 1), vp[i]);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++;
            if (out_valid !== vp[i] || out !== hist[cyc - 3][DATA_W-1:0]) begin
                errors++; $display("FAIL valid_pattern %0d: got %b/%h want %b/%h", i, out_valid, out, vp[i], hist[cyc - 3][DATA_W-1:0]);
            end
        end
        load(5'd4);
        tick();
        checks++;
        if (filling !== 1'b1 || {out_valid, out} !== 17'h0 || delay_q !== 5'd4) begin
            errors++; $display("FAIL same_reload: got filling %b out %h delay %0d want 1 0 4", filling, {out_valid, out}, delay_q);
        end
        tick();
        tick();
        checks++; if ({out_valid, out} !== 17'h0) begin errors++; $display("FAIL same_reload_blank: got %h want 0", {out_valid, out}); end
        tick();
        checks++; if ({out_valid, out} !== hist[cyc - 3]) begin errors++; $display("FAIL same_reload_first: got %h want %h", {out_valid, out}, hist[cyc - 3]); end
    endtask

    task automatic test_reset_mid_fill();
        load(5'd12);
        repeat (3) tick();
        checks++; if (filling !== 1'b1 || delay_q !== 5'd12) begin errors++; $display("FAIL d12_fill: got filling %b delay %0d want 1 12", filling, delay_q); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, out} !== 17'h0) begin errors++; $display("FAIL async_out: got %h want 0", {out_valid, out}); end
        checks++; if (clamped !== 1'b0) begin errors++; $display("FAIL async_clamped: got %b want 0", clamped); end
        checks++; if (delay_q !== DW'(DEFAULT_DELAY)) begin errors++; $display("FAIL async_delay_q: got %0d want %0d", delay_q, DEFAULT_DELAY); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({out_valid, out} !== hist[cyc] || filling !== 1'b0) begin
                errors++; $display("FAIL post_reset_d1 %0d: got %h filling %b want %h filling 0", i, {out_valid, out}, filling, hist[cyc]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_delay();
        test_load_five();
        test_clamp();
        test_reload_in_fill();
        test_valid_pattern();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/variable_delayer.md
VARIABLE_DELAYER -- requirements
Module: variable_delayer

Interface
REQ-001 Parameter WIDTH, default 8: bits per channel sample.
REQ-002 Parameter CHANNELS, default 1: number of parallel channels sharing one delay setting.
REQ-003 Parameter MAX_CYCLES, default 16: maximum delay in clock cycles; legal values are 2 or more.
REQ-004 Parameter DEFAULT_DELAY, default 1: delay active after reset; legal range is 1..MAX_CYCLES.
REQ-005 Local parameter DW SHALL equal $clog2(MAX_CYCLES+1).
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 in  input  CHANNELS*WIDTH  packed samples; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-009 in_valid  input  1  qualifier travelling with in.
REQ-010 delay_i  input  DW  requested delay in cycles.
REQ-011 delay_load  input  1  single-cycle strobe that applies delay_i.
REQ-012 out  output  CHANNELS*WIDTH  delayed samples, registered.
REQ-013 out_valid  output  1  delayed in_valid, gated by the fill state.
REQ-014 delay_q  output  DW  currently active delay after clamping.
REQ-015 filling  output  1  high while in the FILL state.
REQ-016 clamped  output  1  one-cycle pulse when a loaded delay_i was out of range.

Function
REQ-017 Storage SHALL be a circular buffer of MAX_CYCLES entries holding CHANNELS*WIDTH+1 bits (data plus valid) per entry, with a write pointer that wraps from MAX_CYCLES-1 to 0.
REQ-018 The buffer SHALL be written every cycle, independent of in_valid.
REQ-019 With active delay D, in and in_valid sampled at edge t SHALL appear on out and out_valid after edge t+D-1; D=1 SHALL behave exactly like a single register stage.
REQ-020 On delay_load, delay_q SHALL take delay_i clamped to 1..MAX_CYCLES: a value of 0 becomes 1, a value above MAX_CYCLES becomes MAX_CYCLES.
REQ-021 When clamping occurs, clamped SHALL pulse for the cycle after the load; otherwise clamped SHALL be 0.
REQ-022 The state machine SHALL have two states, FILL and RUN, with a fill counter DW bits wide.
REQ-023 A delay_load at edge k SHALL enter FILL and set the counter so that out and out_valid are 0 after edges k..k+D-2, where D is the new delay.
REQ-024 The first output of a new delay SHALL appear after edge k+D-1 and carry the in sampled at edge k; at that point the block SHALL enter RUN.
REQ-025 If the new D is 1, the block SHALL pass straight to RUN with no blanked cycles.
REQ-026 Data written under the previous delay SHALL never appear on out after a delay_load.
REQ-027 A delay_load during FILL SHALL restart the fill count using the newest delay.
REQ-028 A delay_load equal to the current delay_q SHALL still restart FILL.
REQ-029 In FILL, out SHALL be all zeros and out_valid SHALL be 0.
REQ-030 In RUN, out_valid SHALL equal the delayed in_valid; out SHALL be driven regardless of out_valid.
REQ-031 filling SHALL be 1 in FILL and 0 in RUN.
REQ-032 Pointer arithmetic SHALL be modulo MAX_CYCLES for non-power-of-two depths, with no out-of-range indexing.

Reset
REQ-033 While rst_n is low: out=0, out_valid=0, clamped=0, delay_q=DEFAULT_DELAY, write pointer=0.
REQ-034 Reset SHALL enter FILL as if a load of DEFAULT_DELAY occurred at the first edge after release.
REQ-035 Buffer contents need not be cleared; FILL gating guarantees that stale contents are never output.
REQ-036 Reset asserted mid-operation SHALL abandon any fill in progress immediately and asynchronously.

Verification (WIDTH=8, CHANNELS=2, MAX_CYCLES=16, DEFAULT_DELAY=1)
REQ-037 Release reset, drive an incrementing in with in_valid=1 -> out equals in delayed by 1, with no blanked cycle.
REQ-038 delay_load with delay_i=5 at edge k, data 0x0A0A at edge k -> out=0 and out_valid=0 after edges k..k+3; 0x0A0A with out_valid=1 after edge k+4.
REQ-039 delay_i=0, then delay_i=31 -> delay_q=1 with clamped pulsed, then delay_q=16 with clamped pulsed; the delay-16 stream is correct across pointer wrap.
REQ-040 delay_load 8, then delay_load 3 two cycles later -> blanking restarts at the second load; the first valid output is the sample from the second load edge.
REQ-041 Toggle in_valid with pattern 1,0,1,1 at D=4 -> out_valid shows the same pattern 4 cycles later.
REQ-042 Assert rst_n low mid-FILL at D=12 -> all outputs 0 at once; after release, D=1 behaviour resumes.
